// File: rtl/ghost_dir_picker.sv
// Turns one LFSR draw into a legal ghost heading at a maze intersection.
// Optional feature macro: GHOST_DIR_BIAS_EN (adds bias_dir and BIAS_THRESH).
module ghost_dir_picker #(
    parameter bit          ALLOW_REVERSE = 1'b0,
    parameter int unsigned RAND_LSB      = 0
`ifdef GHOST_DIR_BIAS_EN
    ,
    parameter logic [7:0]  BIAS_THRESH   = 8'd64
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [3:0] legal_mask,
    input  logic [1:0] cur_dir,
    input  logic [7:0] rand_in,
`ifdef GHOST_DIR_BIAS_EN
    input  logic [1:0] bias_dir,
`endif
    output logic       lfsr_en,
    output logic [1:0] dir_out,
    output logic       dir_valid,
    output logic       busy,
    output logic       stuck
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_LOAD,
        S_SCAN,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [3:0] mask_q;
    logic [1:0] cur_q;
    logic [1:0] cand_q;
    logic [1:0] cnt_q;
    logic [1:0] dir_q;
    logic       lfsr_en_q;
    logic       dir_valid_q;
    logic       busy_q;
    logic       stuck_q;

    logic [1:0] rev_dir;
    logic       cand_ok;
    logic [1:0] first_cand_d;
    logic [1:0] fb_dir_d;
    logic       fb_stuck_d;

    assign rev_dir = cur_q ^ 2'b10;
    assign cand_ok = mask_q[cand_q] && ((cand_q != rev_dir) || ALLOW_REVERSE);

    always_comb begin
        first_cand_d = rand_in[RAND_LSB +: 2];
`ifdef GHOST_DIR_BIAS_EN
        if (rand_in < BIAS_THRESH) first_cand_d = bias_dir;
`endif
    end

    // Dead end: back out the way we came if possible, otherwise hold heading and flag it.
    always_comb begin
        fb_dir_d   = cur_q;
        fb_stuck_d = 1'b1;
        if (mask_q[rev_dir]) begin
            fb_dir_d   = rev_dir;
            fb_stuck_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            cur_q       <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= '0;
            lfsr_en_q   <= 1'b0;
            dir_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            lfsr_en_q   <= 1'b0;
            dir_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        mask_q    <= legal_mask;
                        cur_q     <= cur_dir;
                        stuck_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        lfsr_en_q <= 1'b1;
                        state_q   <= S_DRAW;
                    end
                end
                S_DRAW: state_q <= S_LOAD;
                S_LOAD: begin
                    // LFSR advanced on the DRAW edge, so rand_in is already the fresh value.
                    cand_q  <= first_cand_d;
                    cnt_q   <= 2'd0;
                    state_q <= S_SCAN;
                end
                S_SCAN: begin
                    if (cand_ok) begin
                        dir_q       <= cand_q;
                        dir_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (cnt_q == 2'd3) begin
                        // Fallback resolves on the fourth rejection edge so a dead end costs no extra cycle.
                        dir_q       <= fb_dir_d;
                        stuck_q     <= fb_stuck_d;
                        dir_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cand_q <= cand_q + 2'd1;
                        cnt_q  <= cnt_q + 2'd1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lfsr_en   = lfsr_en_q;
    assign dir_out   = dir_q;
    assign dir_valid = dir_valid_q;
    assign busy      = busy_q;
    assign stuck     = stuck_q;

endmodule
